i2c_byte_master: RTL and testbench

- Byte-level I2C master engine directly downstream of the ads1115 controller.
- The controller issues START / WRITE / READ / STOP commands over a valid/ready handshake. This block generates the SCL/SDA waveforms, returns read bytes and ACK status, and honours slave clock stretching.
- SCL and SDA are open-drain: the top level maps each `*_oe` = 1 to "drive 0" and each `*_oe` = 0 to "release" (pulled high).

---
 rtl/i2c_byte_master.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_byte_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master engine: START / WRITE / READ / STOP over a valid/ready
// command handshake, with open-drain SCL/SDA enables and clock-stretch support.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a command; SCL held low while the bus is owned
// START_A | repeated-start prefix: release SDA, then release SCL
// START_B | start sequence: both released, SDA low, then SCL low
// BIT     | one of 8 data bit slots (4 quarters each)
// ACKBIT  | 9th bit slot (slave ACK on WRITE, master ACK/NACK on READ)
// STOP_A  | SCL and SDA both driven low
// STOP_B  | release SCL, then release SDA
// DONE    | one-cycle response; a new command may be accepted here
module i2c_byte_master #(
  parameter int CLK_DIV = 63
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_ack,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);

  typedef enum logic [2:0] {
    IDLE, START_A, START_B, BIT, ACKBIT, STOP_A, STOP_B, DONE
  } state_t;

  localparam logic [1:0]  OP_START = 2'd0;
  localparam logic [1:0]  OP_WRITE = 2'd1;
  localparam logic [1:0]  OP_READ  = 2'd2;
  localparam logic [1:0]  OP_STOP  = 2'd3;
  localparam logic [15:0] QLOAD    = 16'(CLK_DIV - 1);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_q;
  logic [15:0] r_qcnt;
  logic [2:0]  r_bit;
  logic [1:0]  r_op;
  logic [7:0]  r_sh;
  logic        r_ack;
  logic        r_busy;
  logic        r_nack;
  logic [7:0]  r_data;

  logic w_scl_oe;
  logic w_sda_oe;
  logic w_cmd_ready;
  logic w_rsp_valid;
  logic w_accept;
  logic w_timed;
  logic w_stall;
  logic w_qend;

  assign w_accept = cmd_valid & w_cmd_ready;
  assign w_timed  = (r_state != IDLE) && (r_state != DONE);
  // A released SCL that is still seen low means the slave is stretching.
  assign w_stall  = ~w_scl_oe & ~scl_in;
  assign w_qend   = w_timed & ~w_stall & (r_qcnt == 16'd0);

  // Line enables and handshake outputs decoded from the current state.
  always_comb begin
    w_scl_oe    = 1'b0;
    w_sda_oe    = 1'b0;
    w_cmd_ready = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_cmd_ready = 1'b1;
        w_scl_oe    = r_busy;
      end
      DONE: begin
        w_cmd_ready = 1'b1;
        w_rsp_valid = 1'b1;
        w_scl_oe    = r_busy;
      end
      START_A: w_scl_oe = (r_q == 2'd0);
      START_B: begin
        w_sda_oe = (r_q != 2'd0);
        w_scl_oe = (r_q == 2'd2);
      end
      BIT: begin
        w_scl_oe = ~r_q[1];
        w_sda_oe = (r_op == OP_WRITE) & ~r_sh[7];
      end
      ACKBIT: begin
        w_scl_oe = ~r_q[1];
        w_sda_oe = (r_op == OP_READ) & r_ack;
      end
      STOP_A: begin
        w_scl_oe = 1'b1;
        w_sda_oe = 1'b1;
      end
      STOP_B: w_sda_oe = (r_q == 2'd0);
      default: begin
        w_scl_oe = 1'b0;
        w_sda_oe = 1'b0;
      end
    endcase
  end

  // Next-state: quarter-driven sequencing, command dispatch on accept.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = IDLE;
      DONE:    w_next = IDLE;
      START_A: if (w_qend && r_q == 2'd1) w_next = START_B;
      START_B: if (w_qend && r_q == 2'd2) w_next = DONE;
      BIT:     if (w_qend && r_q == 2'd3 && r_bit == 3'd7) w_next = ACKBIT;
      ACKBIT:  if (w_qend && r_q == 2'd3) w_next = DONE;
      STOP_A:  if (w_qend) w_next = STOP_B;
      STOP_B:  if (w_qend && r_q == 2'd1) w_next = DONE;
      default: w_next = IDLE;
    endcase
    if (w_accept) begin
      case (cmd_op)
        OP_START: w_next = r_busy ? START_A : START_B;
        OP_STOP:  w_next = r_busy ? STOP_A  : DONE;
        default:  w_next = r_busy ? BIT     : DONE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Command latch, quarter/bit timing, shift register and response status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= 2'd0;
      r_qcnt <= 16'd0;
      r_bit  <= 3'd0;
      r_op   <= OP_START;
      r_sh   <= 8'd0;
      r_ack  <= 1'b0;
      r_busy <= 1'b0;
      r_nack <= 1'b0;
      r_data <= 8'd0;
    end else begin
      if (w_accept) begin
        r_op   <= cmd_op;
        r_sh   <= cmd_data;
        r_ack  <= cmd_ack;
        r_q    <= 2'd0;
        r_qcnt <= QLOAD;
        r_bit  <= 3'd0;
      end else if (w_timed) begin
        if (w_stall) begin
          r_qcnt <= QLOAD;
        end else if (r_qcnt != 16'd0) begin
          r_qcnt <= r_qcnt - 16'd1;
        end else begin
          r_qcnt <= QLOAD;
          r_q    <= (w_next != r_state) ? 2'd0 : r_q + 2'd1;
          if (r_state == BIT && r_q == 2'd3) begin
            r_sh  <= {r_sh[6:0], sda_in};
            r_bit <= r_bit + 3'd1;
          end
        end
      end
      if (w_next == DONE) begin
        case (r_state)
          START_B: begin
            r_busy <= 1'b1;
            r_nack <= 1'b0;
          end
          ACKBIT: begin
            r_nack <= (r_op == OP_WRITE) & sda_in;
            if (r_op == OP_READ) r_data <= r_sh;
          end
          STOP_B: begin
            r_busy <= 1'b0;
            r_nack <= 1'b0;
          end
          // Direct IDLE/DONE -> DONE only happens for commands issued without
          // bus ownership: data commands report an error, STOP does not.
          default: r_nack <= (cmd_op == OP_WRITE) || (cmd_op == OP_READ);
        endcase
      end
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign rsp_valid = w_rsp_valid;
  assign rsp_data  = r_data;
  assign rsp_nack  = r_nack;
  assign busy      = r_busy;
  assign scl_oe    = w_scl_oe;
  assign sda_oe    = w_sda_oe;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master with a small open-drain slave model.
module tb_i2c_byte_master;

  localparam int CD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_data = 8'd0;
  logic       cmd_ack = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  logic       busy;
  logic       scl_oe;
  logic       sda_oe;
  logic       scl_in;
  logic       sda_in;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int slot = 0;
  int n_valid = 0;
  int n_start = 0;
  int n_stop = 0;
  int oe_cnt = 0;
  int stall_cnt = 0;

  logic [8:0] pat = 9'h1FF;
  logic [8:0] mon = 9'd0;
  logic       stretch_arm = 1'b0;
  logic       prev_oe = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       slave_low;
  logic       stretch_act;
  logic [3:0] sidx;

  i2c_byte_master #(.CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_ack(cmd_ack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
    .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .scl_in(scl_in), .sda_in(sda_in)
  );

  always #5 clk = ~clk;

  // Slave: pat[8] is the line level for slot 0 ... pat[0] for slot 8 (1 = release).
  assign sidx        = 4'(8 - slot);
  assign slave_low   = (slot < 9) && !pat[sidx];
  assign stretch_act = stretch_arm && (slot == 3) && !scl_oe && (stall_cnt < 50);
  assign scl_in      = ~scl_oe & ~stretch_act;
  assign sda_in      = ~sda_oe & ~slave_low;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (stretch_act) stall_cnt <= stall_cnt + 1;
  end

  // Bus monitor: slot tracking, START/STOP detection, bits seen at SCL rise.
  always @(negedge clk) begin
    if (rsp_valid) n_valid <= n_valid + 1;
    if (scl_oe | sda_oe) oe_cnt <= oe_cnt + 1;
    if (!rst_n || rsp_valid) slot <= 0;
    else if (scl_oe && !prev_oe) slot <= slot + 1;
    prev_oe <= scl_oe;
    if (scl_in && prev_scl && !sda_in && prev_sda) n_start <= n_start + 1;
    if (scl_in && prev_scl && sda_in && !prev_sda) n_stop <= n_stop + 1;
    if (scl_in && !prev_scl) mon <= {mon[7:0], sda_in};
    prev_scl <= scl_in;
    prev_sda <= sda_in;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [7:0] d, input logic a,
                        input logic [8:0] p, output int lat);
    int acc;
    int n;
    pat = p;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_ack   = a;
    acc       = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - acc;
    @(negedge clk);
    chk("rsp_pulse_len", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int oe0;
    int ns0;
    int n;

    #23;
    chk("rst_scl_oe",    scl_oe,    0);
    chk("rst_sda_oe",    sda_oe,    0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data",  rsp_data,  0);
    chk("rst_rsp_nack",  rsp_nack,  0);
    chk("rst_busy",      busy,      0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // START, WRITE 0x90, STOP
    do_cmd(2'd0, 8'h00, 1'b0, 9'h1FF, lat);
    chk("start_lat", lat, 3*CD+1);
    chk("start_busy", busy, 1);
    chk("start_cond", n_start, 1);
    chk("start_scl_hold", scl_oe, 1);
    do_cmd(2'd1, 8'h90, 1'b0, 9'h1FE, lat);
    chk("wr90_lat", lat, 36*CD+1);
    chk("wr90_bits", mon, 9'h120);
    chk("wr90_nack", rsp_nack, 0);
    do_cmd(2'd3, 8'h00, 1'b0, 9'h1FF, lat);
    chk("stop_lat", lat, 3*CD+1);
    chk("stop_busy", busy, 0);
    chk("stop_cond", n_stop, 1);
    chk("rsp_count", n_valid, 3);
    chk("stop_lines", {scl_oe, sda_oe}, 0);

    // WRITE 0x01 NACKed by slave
    do_cmd(2'd0, 8'h00, 1'b0, 9'h1FF, lat);
    do_cmd(2'd1, 8'h01, 1'b0, 9'h1FF, lat);
    chk("wr01_nack", rsp_nack, 1);
    chk("wr01_bits", mon, 9'h003);
    repeat (5) @(negedge clk);
    chk("nack_scl_hold", scl_oe, 1);
    chk("nack_busy", busy, 1);
    do_cmd(2'd3, 8'h00, 1'b0, 9'h1FF, lat);
    chk("stop2_lat", lat, 3*CD+1);
    chk("stop2_nack", rsp_nack, 0);
    chk("stop2_busy", busy, 0);

    // WRITE 0x91, READ with ACK (0xA5), READ with NACK (0x3C), repeated START
    do_cmd(2'd0, 8'h00, 1'b0, 9'h1FF, lat);
    do_cmd(2'd1, 8'h91, 1'b0, 9'h1FE, lat);
    chk("wr91_nack", rsp_nack, 0);
    do_cmd(2'd2, 8'h00, 1'b1, {8'hA5, 1'b1}, lat);
    chk("rd1_lat", lat, 36*CD+1);
    chk("rd1_data", rsp_data, 8'hA5);
    chk("rd1_bits", mon, 9'h14A);
    chk("rd1_nack", rsp_nack, 0);
    do_cmd(2'd2, 8'h00, 1'b0, {8'h3C, 1'b1}, lat);
    chk("rd2_data", rsp_data, 8'h3C);
    chk("rd2_bits", mon, 9'h079);
    ns0 = n_start;
    do_cmd(2'd0, 8'h00, 1'b0, 9'h1FF, lat);
    chk("rstart_lat", lat, 5*CD+1);
    chk("rstart_cond", n_start, ns0 + 1);
    chk("rstart_busy", busy, 1);
    do_cmd(2'd3, 8'h00, 1'b0, 9'h1FF, lat);

    // Clock stretch of 50 cycles in bit 3
    do_cmd(2'd0, 8'h00, 1'b0, 9'h1FF, lat);
    stretch_arm = 1'b1;
    do_cmd(2'd1, 8'h5A, 1'b0, 9'h1FE, lat);
    stretch_arm = 1'b0;
    chk("stretch_lat", lat, 36*CD+1+50);
    chk("stretch_cycles", stall_cnt, 50);
    chk("stretch_bits", mon, 9'h0B4);
    chk("stretch_nack", rsp_nack, 0);
    do_cmd(2'd3, 8'h00, 1'b0, 9'h1FF, lat);

    // Data commands and STOP without bus ownership
    oe0 = oe_cnt;
    do_cmd(2'd2, 8'h00, 1'b1, 9'h1FF, lat);
    chk("err_rd_lat", lat, 1);
    chk("err_rd_nack", rsp_nack, 1);
    chk("err_rd_data", rsp_data, 8'h3C);
    chk("err_rd_lines", oe_cnt, oe0);
    do_cmd(2'd3, 8'h00, 1'b0, 9'h1FF, lat);
    chk("err_stop_lat", lat, 1);
    chk("err_stop_nack", rsp_nack, 0);
    chk("err_stop_busy", busy, 0);

    // Reset during bit 5 of a WRITE
    do_cmd(2'd0, 8'h00, 1'b0, 9'h1FF, lat);
    pat = 9'h1FE;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_data  = 8'hFF;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_not_ready", cmd_ready, 0);
    n = 0;
    while (slot != 5 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_bit5", slot, 5);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_scl_oe", scl_oe, 0);
    chk("midrst_sda_oe", sda_oe, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    ns0 = n_start;
    do_cmd(2'd0, 8'h00, 1'b0, 9'h1FF, lat);
    chk("post_rst_start_lat", lat, 3*CD+1);
    chk("post_rst_start_cond", n_start, ns0 + 1);
    chk("post_rst_busy", busy, 1);
    do_cmd(2'd3, 8'h00, 1'b0, 9'h1FF, lat);
    chk("post_rst_stop_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
